// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, 3-bit palette, default sprite size
// and the draw-engine state encoding.
package game_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 8;

  localparam logic [2:0] COL_BLACK   = 3'b000;
  localparam logic [2:0] COL_BLUE    = 3'b001;
  localparam logic [2:0] COL_GREEN   = 3'b010;
  localparam logic [2:0] COL_CYAN    = 3'b011;
  localparam logic [2:0] COL_RED     = 3'b100;
  localparam logic [2:0] COL_MAGENTA = 3'b101;
  localparam logic [2:0] COL_YELLOW  = 3'b110;
  localparam logic [2:0] COL_WHITE   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ERASE  = 2'd1,
    ST_DRAW   = 2'd2,
    ST_FINISH = 2'd3
  } draw_state_e;

endpackage

// File: rtl/player_draw_engine_if.sv
// Request handshake from the movement logic plus the pixel bus that feeds
// the vga_adapter directly.
interface player_draw_engine_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [2:0] req_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_x, req_y, req_colour,
    input  req_ready, x, y, colour, plot, busy, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour,
    output req_ready, x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/rect_scanner.sv
// Row-major walker over a W x H rectangle; col is the low counter bits,
// row the next bits. last flags the final pixel of the scan.
module rect_scanner #(
  parameter int W = 16,
  parameter int H = 8,
  localparam int CW = $clog2(W),
  localparam int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam int NW = CW + RW;
  localparam logic [NW-1:0] LAST_IDX = NW'(W * H - 1);
  localparam logic [NW-1:0] ONE      = NW'(1);

  logic [NW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign col  = cnt_q[CW-1:0];
  assign row  = cnt_q[NW-1:CW];
  assign last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/player_draw_engine.sv
// Erase-then-draw sprite plotter: one registered pixel per clock towards the
// vga_adapter, with off-screen pixels suppressed but still scanned.
module player_draw_engine #(
  parameter int         SPRITE_W  = game_pkg::SPRITE_W,
  parameter int         SPRITE_H  = game_pkg::SPRITE_H,
  parameter int         SCREEN_W  = game_pkg::SCREEN_W,
  parameter int         SCREEN_H  = game_pkg::SCREEN_H,
  parameter logic [2:0] BG_COLOUR = game_pkg::COL_BLACK
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  player_draw_engine_if.slave  bus
);

  import game_pkg::*;

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  draw_state_e state_q, state_d;
  logic        have_prev_q, have_prev_d;
  logic [7:0]  prev_x_q, prev_x_d, new_x_q, new_x_d, x_q, x_d;
  logic [6:0]  prev_y_q, prev_y_d, new_y_q, new_y_d, y_q, y_d;
  logic [2:0]  new_colour_q, new_colour_d, colour_q, colour_d;
  logic        plot_q, plot_d, done_q, done_d;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last;
  logic          scan_clear, scan_en, emit;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [2:0]    pix_colour;
  logic [8:0]    x_sum;
  logic [7:0]    y_sum;

  function automatic logic on_screen(input logic [8:0] xs, input logic [7:0] ys);
    return ({23'd0, xs} < 32'(SCREEN_W)) && ({24'd0, ys} < 32'(SCREEN_H));
  endfunction

  rect_scanner #(
    .W (SPRITE_W),
    .H (SPRITE_H)
  ) u_scan (
    .clk    (CLOCK_50),
    .rst_n  (resetn),
    .clear  (scan_clear),
    .enable (scan_en),
    .col    (col),
    .row    (row),
    .last   (last)
  );

  // The scanner leads the output registers by one cycle: the pixel at the
  // current count is computed here and lands on x/y/plot at the next edge.
  always_comb begin
    state_d      = state_q;
    have_prev_d  = have_prev_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_colour_d = new_colour_q;
    done_d       = 1'b0;
    scan_en      = 1'b0;
    scan_clear   = 1'b0;
    emit         = 1'b0;
    base_x       = prev_x_q;
    base_y       = prev_y_q;
    pix_colour   = BG_COLOUR;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          new_x_d      = bus.req_x;
          new_y_d      = bus.req_y;
          new_colour_d = bus.req_colour;
          scan_en      = 1'b1;
          emit         = 1'b1;
          if (have_prev_q) begin
            state_d = ST_ERASE;
          end else begin
            state_d    = ST_DRAW;
            base_x     = bus.req_x;
            base_y     = bus.req_y;
            pix_colour = bus.req_colour;
          end
        end
      end
      ST_ERASE: begin
        scan_en = 1'b1;
        emit    = 1'b1;
        if (last) begin
          scan_clear = 1'b1;
          state_d    = ST_DRAW;
        end
      end
      ST_DRAW: begin
        base_x     = new_x_q;
        base_y     = new_y_q;
        pix_colour = new_colour_q;
        scan_en    = 1'b1;
        emit       = 1'b1;
        if (last) begin
          scan_clear  = 1'b1;
          state_d     = ST_FINISH;
          prev_x_d    = new_x_q;
          prev_y_d    = new_y_q;
          have_prev_d = 1'b1;
        end
      end
      ST_FINISH: begin
        // First FINISH cycle shows the last plot; the second shows done.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    x_sum    = {1'b0, base_x} + 9'(col);
    y_sum    = {1'b0, base_y} + 8'(row);
    x_d      = emit ? x_sum[7:0] : x_q;
    y_d      = emit ? y_sum[6:0] : y_q;
    colour_d = emit ? pix_colour : colour_q;
    plot_d   = emit & on_screen(x_sum, y_sum);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      have_prev_q  <= 1'b0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_colour_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      have_prev_q  <= have_prev_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_colour_q <= new_colour_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.done      = done_q;
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_draw_engine.sv
// Bench for player_draw_engine: a per-request pixel list built from the
// sprite/screen rules is compared against the pixel bus cycle by cycle.
module tb_player_draw_engine;

  localparam int SW    = 16;
  localparam int SH    = 8;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam logic [2:0] BG = 3'b000;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  player_draw_engine_if bus();

  player_draw_engine dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  pix_t exp_q[$];

  bit         m_have_prev = 1'b0;
  int         m_prev_x    = 0;
  int         m_prev_y    = 0;
  int         obs_plots;
  logic [7:0] obs_last_x;
  logic [6:0] obs_last_y;

  task automatic add_rect(input int bx, input int by, input logic [2:0] c);
    pix_t e;
    int   xs, ys;
    for (int r = 0; r < SH; r++) begin
      for (int k = 0; k < SW; k++) begin
        xs  = bx + k;
        ys  = by + r;
        e.x = 8'(xs);
        e.y = 7'(ys);
        e.c = c;
        e.p = (xs < SCR_W) && (ys < SCR_H);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic apply_reset();
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    m_have_prev = 1'b0;
  endtask

  // Issues one request and checks every cycle until one cycle after done.
  // hold keeps req_valid asserted with another request while busy;
  // abort_at >= 0 pulls resetn low while that pixel index is on the bus.
  task automatic run_request(input logic [7:0] rx, input logic [6:0] ry, input logic [2:0] rc,
                             input bit hold, input logic [7:0] hx, input logic [6:0] hy,
                             input logic [2:0] hc, input int abort_at);
    int   n;
    int   waited;
    pix_t e;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 1000) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: req_ready=%b after %0d cycles, required 1", bus.req_ready, waited);
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_x      = rx;
    bus.req_y      = ry;
    bus.req_colour = rc;
    exp_q.delete();
    if (m_have_prev) add_rect(m_prev_x, m_prev_y, BG);
    add_rect(int'(rx), int'(ry), rc);
    n = exp_q.size();
    obs_plots  = 0;
    obs_last_x = '0;
    obs_last_y = '0;
    @(posedge clk); #1;
    if (hold) begin
      bus.req_x      = hx;
      bus.req_y      = hy;
      bus.req_colour = hc;
    end else begin
      bus.req_valid = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      e = exp_q[i];
      total++;
      if (bus.plot !== e.p || bus.x !== e.x || bus.y !== e.y || bus.colour !== e.c) begin
        bad++;
        $display("FAIL pixel[%0d] req(%0d,%0d): got plot=%b x=%0d y=%0d c=%b, required plot=%b x=%0d y=%0d c=%b",
                 i, rx, ry, bus.plot, bus.x, bus.y, bus.colour, e.p, e.x, e.y, e.c);
      end
      total++;
      if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL status[%0d]: got busy=%b ready=%b done=%b, required 1 0 0",
                 i, bus.busy, bus.req_ready, bus.done);
      end
      if (bus.plot === 1'b1) begin
        obs_plots++;
        obs_last_x = bus.x;
        obs_last_y = bus.y;
      end
      if (i == abort_at) begin
        resetn = 1'b0;
        #1;
        total++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
          bad++;
          $display("FAIL abort_reset: got plot=%b busy=%b done=%b ready=%b, required 0 0 0 1",
                   bus.plot, bus.busy, bus.done, bus.req_ready);
        end
        m_have_prev   = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    if (bus.done !== 1'b1 || bus.plot !== 1'b0 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle req(%0d,%0d): got done=%b plot=%b busy=%b ready=%b, required 1 0 1 0",
               rx, ry, bus.done, bus.plot, bus.busy, bus.req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (bus.done !== 1'b0 || bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_done req(%0d,%0d): got done=%b plot=%b busy=%b ready=%b, required 0 0 0 1",
               rx, ry, bus.done, bus.plot, bus.busy, bus.req_ready);
    end
    m_have_prev = 1'b1;
    m_prev_x    = int'(rx);
    m_prev_y    = int'(ry);
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_colour = '0;
    #12;
    total++;
    if (bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'd0 || bus.plot !== 1'b0) begin
      bad++;
      $display("FAIL reset_pixel: got x=%0d y=%0d c=%b plot=%b, required 0 0 000 0",
               bus.x, bus.y, bus.colour, bus.plot);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctrl: got busy=%b done=%b ready=%b, required 0 0 1",
               bus.busy, bus.done, bus.req_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_after_reset: got plot=%b busy=%b ready=%b, required 0 0 1",
               bus.plot, bus.busy, bus.req_ready);
    end
    m_have_prev = 1'b0;
  endtask

  task automatic test_first_draw();
    run_request(8'd80, 7'd50, 3'b010, 1'b0, '0, '0, '0, -1);
    total++;
    if (obs_plots != 128) begin
      bad++;
      $display("FAIL first_plot_count: got %0d, required 128", obs_plots);
    end
    total++;
    if (obs_last_x !== 8'd95 || obs_last_y !== 7'd57) begin
      bad++;
      $display("FAIL first_last_pixel: got (%0d,%0d), required (95,57)", obs_last_x, obs_last_y);
    end
  endtask

  task automatic test_move();
    run_request(8'd81, 7'd50, 3'b010, 1'b0, '0, '0, '0, -1);
    total++;
    if (obs_plots != 256) begin
      bad++;
      $display("FAIL move_plot_count: got %0d, required 256", obs_plots);
    end
  endtask

  task automatic test_same_request();
    run_request(8'd81, 7'd50, 3'b010, 1'b0, '0, '0, '0, -1);
  endtask

  task automatic test_back_to_back();
    run_request(8'd40, 7'd60, 3'b110, 1'b1, 8'd100, 7'd20, 3'b101, -1);
    total++;
    if (bus.req_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL held_request_ready: got valid=%b ready=%b, required 1 1", bus.req_valid, bus.req_ready);
    end
    run_request(8'd100, 7'd20, 3'b101, 1'b0, '0, '0, '0, -1);
  endtask

  task automatic test_mid_reset();
    run_request(8'd30, 7'd20, 3'b011, 1'b0, '0, '0, '0, SW * SH + 39);
    run_request(8'd10, 7'd10, 3'b111, 1'b0, '0, '0, '0, -1);
    total++;
    if (obs_plots != 128) begin
      bad++;
      $display("FAIL post_reset_plots: got %0d, required 128 (no erase)", obs_plots);
    end
  endtask

  task automatic test_clip();
    apply_reset();
    run_request(8'd150, 7'd115, 3'b100, 1'b0, '0, '0, '0, -1);
    total++;
    if (obs_plots != 50) begin
      bad++;
      $display("FAIL clip_plot_count: got %0d, required 50", obs_plots);
    end
  endtask

  task automatic test_random();
    logic [7:0] rx;
    logic [6:0] ry;
    logic [2:0] rc;
    for (int t = 0; t < 8; t++) begin
      rx = 8'($urandom_range(0, 255));
      ry = 7'($urandom_range(0, 127));
      rc = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_request(rx, ry, rc, 1'b0, '0, '0, '0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_move();
    test_same_request();
    test_back_to_back();
    test_mid_reset();
    test_clip();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
